// File: rtl/hdlc_rx_deframer.sv
// Bit-serial HDLC receive deframer: flag/abort detection, zero removal, LSB-first byte assembly and frame status.
// Define RX_FCS_CHECK_EN to add the CRC-16 FCS check that drives Rx_FCSerr.
module hdlc_rx_deframer #(
    parameter int MAX_BYTES = 128,
    parameter int SIZE_W    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx,
    output logic              RxD,
    output logic              Rx_FlagDetect,
    output logic              Rx_AbortDetect,
    output logic              Rx_ValidFrame,
    output logic              Rx_StartZeroDetect,
    output logic              ZeroDetect,
    output logic [7:0]        Rx_Data,
    output logic              Rx_NewByte,
    output logic              Rx_WrBuff,
    output logic              Rx_EoF,
    output logic              Rx_AbortSignal,
    output logic              Rx_FrameError,
    output logic              Rx_Overflow,
    output logic [SIZE_W-1:0] Rx_FrameSize,
    output logic              Rx_FCSerr
);

    // state  | meaning
    // IDLE   | hunting for an opening flag
    // FRAME  | between opening and closing flag, data bits assembled
    typedef enum logic {S_IDLE, S_FRAME} state_t;

    localparam logic [SIZE_W-1:0] MAX_CNT = SIZE_W'(MAX_BYTES);

    state_t              state_q, state_d;
    logic                rxd_q;
    logic [7:0]          win_q, win_d;
    logic                flag_q, abort_q;
    logic [2:0]          skip_q;
    logic [2:0]          ones_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          shift_q, shift_d;
    logic [SIZE_W-1:0]   byte_cnt_q;
    logic [7:0]          data_q;
    logic                new_byte_q, wr_buff_q, zero_q, start_q, overflow_q;
    logic                eof_pend_q, abort_pend_q, eof_q, abort_sig_q;
    logic                frame_err_q;
    logic [SIZE_W-1:0]   frame_size_q;
    logic                open_frame, close_frame, abort_frame, rearm;
    logic                data_bit, bit_en, drop, take;

    assign win_d    = {rxd_q, win_q[7:1]};
    assign data_bit = win_q[0];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rxd_q   <= 1'b1;
            win_q   <= 8'hFF;
            flag_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            rxd_q   <= Rx;
            win_q   <= win_d;
            flag_q  <= (win_d == 8'h7E);
            abort_q <= (win_d == 8'hFE);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        open_frame  = 1'b0;
        close_frame = 1'b0;
        abort_frame = 1'b0;
        rearm       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flag_q && !abort_q) begin
                    state_d    = S_FRAME;
                    open_frame = 1'b1;
                end
            end
            S_FRAME: begin
                if (abort_q) begin
                    state_d     = S_IDLE;
                    abort_frame = 1'b1;
                end else if (flag_q) begin
                    if (byte_cnt_q == '0 && bit_cnt_q == 3'd0) begin
                        rearm = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        close_frame = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The flag that opened the frame is still in the window; skip its remaining bits as they leave.
    assign bit_en  = (state_q == S_FRAME) && (skip_q == 3'd0) && !flag_q && !abort_q;
    assign drop    = bit_en && !data_bit && (ones_q == 3'd5);
    assign take    = bit_en && !drop;
    assign shift_d = {data_bit, shift_q[7:1]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            skip_q       <= 3'd0;
            ones_q       <= 3'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_cnt_q   <= '0;
            data_q       <= 8'h00;
            new_byte_q   <= 1'b0;
            wr_buff_q    <= 1'b0;
            zero_q       <= 1'b0;
            start_q      <= 1'b0;
            overflow_q   <= 1'b0;
            eof_pend_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            eof_q        <= 1'b0;
            abort_sig_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_size_q <= '0;
        end else begin
            zero_q       <= drop;
            start_q      <= open_frame;
            new_byte_q   <= 1'b0;
            wr_buff_q    <= 1'b0;
            eof_pend_q   <= close_frame || abort_frame;
            abort_pend_q <= abort_frame;
            eof_q        <= eof_pend_q;
            abort_sig_q  <= abort_pend_q;

            if (open_frame || rearm) begin
                skip_q    <= 3'd7;
                ones_q    <= 3'd0;
                bit_cnt_q <= 3'd0;
            end else if (skip_q != 3'd0) begin
                skip_q <= skip_q - 3'd1;
            end

            if (open_frame) begin
                byte_cnt_q <= '0;
                overflow_q <= 1'b0;
            end else if (new_byte_q && !wr_buff_q) begin
                overflow_q <= 1'b1;
            end

            if (bit_en) begin
                if (!data_bit) begin
                    ones_q <= 3'd0;
                end else if (ones_q != 3'd5) begin
                    ones_q <= ones_q + 3'd1;
                end
            end

            if (take) begin
                shift_q   <= shift_d;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    data_q     <= shift_d;
                    new_byte_q <= 1'b1;
                    wr_buff_q  <= (byte_cnt_q != MAX_CNT);
                    if (byte_cnt_q != MAX_CNT) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end
            end

            if (close_frame) begin
                frame_err_q  <= (bit_cnt_q != 3'd0);
                frame_size_q <= byte_cnt_q;
            end else if (abort_frame) begin
                frame_err_q  <= 1'b0;
                frame_size_q <= byte_cnt_q;
            end
        end
    end

`ifdef RX_FCS_CHECK_EN
    logic [15:0] crc_q;
    logic        fcs_err_q;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            crc_q     <= 16'h0000;
            fcs_err_q <= 1'b0;
        end else begin
            if (open_frame) begin
                crc_q <= 16'h0000;
            end else if (take && bit_cnt_q == 3'd7) begin
                crc_q <= crc16_byte(crc_q, shift_d);
            end
            if (close_frame) begin
                fcs_err_q <= (crc_q != 16'h0000) || (bit_cnt_q != 3'd0);
            end else if (abort_frame) begin
                fcs_err_q <= 1'b0;
            end
        end
    end

    assign Rx_FCSerr = fcs_err_q;
`else
    assign Rx_FCSerr = 1'b0;
`endif

    assign RxD                = rxd_q;
    assign Rx_FlagDetect      = flag_q;
    assign Rx_AbortDetect     = abort_q;
    assign Rx_ValidFrame      = (state_q == S_FRAME);
    assign Rx_StartZeroDetect = start_q;
    assign ZeroDetect         = zero_q;
    assign Rx_Data            = data_q;
    assign Rx_NewByte         = new_byte_q;
    assign Rx_WrBuff          = wr_buff_q;
    assign Rx_EoF             = eof_q;
    assign Rx_AbortSignal     = abort_sig_q;
    assign Rx_FrameError      = frame_err_q;
    assign Rx_Overflow        = overflow_q;
    assign Rx_FrameSize       = frame_size_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench for hdlc_rx_deframer: directed and random frames against a frame-level reference model.
module tb_hdlc_rx_deframer;

    localparam int MAX_BYTES = 128;
    localparam int SIZE_W    = 8;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Rx;
    logic              RxD;
    logic              Rx_FlagDetect;
    logic              Rx_AbortDetect;
    logic              Rx_ValidFrame;
    logic              Rx_StartZeroDetect;
    logic              ZeroDetect;
    logic [7:0]        Rx_Data;
    logic              Rx_NewByte;
    logic              Rx_WrBuff;
    logic              Rx_EoF;
    logic              Rx_AbortSignal;
    logic              Rx_FrameError;
    logic              Rx_Overflow;
    logic [SIZE_W-1:0] Rx_FrameSize;
    logic              Rx_FCSerr;

    hdlc_rx_deframer #(.MAX_BYTES(MAX_BYTES), .SIZE_W(SIZE_W)) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxD(RxD),
        .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_StartZeroDetect(Rx_StartZeroDetect),
        .ZeroDetect(ZeroDetect), .Rx_Data(Rx_Data), .Rx_NewByte(Rx_NewByte),
        .Rx_WrBuff(Rx_WrBuff), .Rx_EoF(Rx_EoF), .Rx_AbortSignal(Rx_AbortSignal),
        .Rx_FrameError(Rx_FrameError), .Rx_Overflow(Rx_Overflow),
        .Rx_FrameSize(Rx_FrameSize), .Rx_FCSerr(Rx_FCSerr)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [7:0] data; logic wr; } byte_exp_t;
    typedef struct { int size; logic err; logic abrt; logic ovf; logic fcs; int zeros; } eof_exp_t;

    int        exp_flag[$];
    int        exp_abort[$];
    byte_exp_t exp_bytes[$];
    eof_exp_t  exp_eof[$];
    bit        frame_bits[$];
    logic [7:0] last8 = 8'hFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected or missing event at cycle %0d", name, cyc);
    endtask

`ifdef RX_FCS_CHECK_EN
    function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = ((c[0] ^ b[i]) != 1'b0) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction
`endif

    // Line-level model: any 8-bit history matching flag or abort predicts a pulse two cycles later.
    task automatic send_bit(input logic b);
        @(posedge Clk);
        #1;
        Rx = b;
        last8 = {last8[6:0], b};
        if (last8 == 8'h7E) exp_flag.push_back(cyc + 2);
        if (last8 == 8'h7F) exp_abort.push_back(cyc + 2);
    endtask

    task automatic send_flag();
        send_bit(1'b0);
        repeat (6) send_bit(1'b1);
        send_bit(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int j = 0; j < 8; j++) frame_bits.push_back(b[j]);
    endtask

    task automatic run_frame(input bit end_abort);
        bit         tx[$];
        int         ones;
        int         zeros;
        int         nbits;
        int         nbytes;
        logic [7:0] b;
        byte_exp_t  be;
        eof_exp_t   ee;
`ifdef RX_FCS_CHECK_EN
        logic [15:0] crc;
        crc = 16'h0000;
`endif
        ones  = 0;
        zeros = 0;
        foreach (frame_bits[i]) begin
            tx.push_back(frame_bits[i]);
            if (frame_bits[i]) begin
                ones++;
                if (ones == 5) begin
                    tx.push_back(1'b0);
                    zeros++;
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        nbits  = frame_bits.size();
        nbytes = nbits / 8;
        for (int i = 0; i < nbytes; i++) begin
            for (int j = 0; j < 8; j++) b[j] = frame_bits[8 * i + j];
            be.data = b;
            be.wr   = (i < MAX_BYTES);
            exp_bytes.push_back(be);
`ifdef RX_FCS_CHECK_EN
            crc = crc_ref(crc, b);
`endif
        end
        ee.size  = (nbytes > MAX_BYTES) ? MAX_BYTES : nbytes;
        ee.abrt  = end_abort;
        ee.err   = !end_abort && ((nbits % 8) != 0);
        ee.ovf   = (nbytes > MAX_BYTES);
        ee.zeros = zeros;
`ifdef RX_FCS_CHECK_EN
        ee.fcs   = end_abort ? 1'b0 : (ee.err ? 1'b1 : (crc != 16'h0000));
`else
        ee.fcs   = 1'b0;
`endif
        exp_eof.push_back(ee);

        send_flag();
        foreach (tx[i]) send_bit(tx[i]);
        if (end_abort) begin
            send_bit(1'b0);
            repeat (7) send_bit(1'b1);
        end else begin
            send_flag();
        end
        frame_bits.delete();
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    logic vf1 = 1'b0, vf2 = 1'b0, ovf1 = 1'b0, nb1 = 1'b0, wr1 = 1'b0;
    int   zd_cnt = 0;

    always @(negedge Clk) begin
        int        t;
        byte_exp_t be;
        eof_exp_t  ee;
        if (!Rst) begin
            if (Rx_FlagDetect) begin
                if (exp_flag.size() == 0) fail_evt("flag_detect");
                else begin
                    t = exp_flag.pop_front();
                    check("flag_detect_cycle", cyc, t);
                end
            end
            if (Rx_AbortDetect) begin
                if (exp_abort.size() == 0) fail_evt("abort_detect");
                else begin
                    t = exp_abort.pop_front();
                    check("abort_detect_cycle", cyc, t);
                end
            end
            if (Rx_NewByte) begin
                if (exp_bytes.size() == 0) fail_evt("new_byte");
                else begin
                    be = exp_bytes.pop_front();
                    check("rx_data", Rx_Data, be.data);
                    check("rx_wrbuff", Rx_WrBuff, be.wr);
                end
            end
            if (Rx_WrBuff && !Rx_NewByte) fail_evt("wrbuff_without_newbyte");
            if (ZeroDetect) zd_cnt++;
            if (Rx_StartZeroDetect) begin
                check("start_on_valid_rise", {Rx_ValidFrame, vf1}, 2'b10);
                check("ovf_clear_on_open", Rx_Overflow, 1'b0);
            end
            if (Rx_ValidFrame && !vf1 && !Rx_StartZeroDetect) fail_evt("valid_rise_without_start");
            if (Rx_Overflow && !ovf1) check("ovf_rise_after_extra_byte", {nb1, wr1}, 2'b10);
            if (Rx_AbortSignal && !Rx_EoF) fail_evt("abort_signal_without_eof");
            if (Rx_EoF) begin
                if (exp_eof.size() == 0) fail_evt("eof");
                else begin
                    ee = exp_eof.pop_front();
                    check("eof_after_valid_fall", {vf2, vf1, Rx_ValidFrame}, 3'b100);
                    check("frame_size", Rx_FrameSize, ee.size);
                    check("frame_error", Rx_FrameError, ee.err);
                    check("abort_signal", Rx_AbortSignal, ee.abrt);
                    check("overflow_at_eof", Rx_Overflow, ee.ovf);
                    check("fcs_err", Rx_FCSerr, ee.fcs);
                    check("zero_detect_count", zd_cnt, ee.zeros);
                end
                zd_cnt = 0;
            end
            vf2  = vf1;
            vf1  = Rx_ValidFrame;
            ovf1 = Rx_Overflow;
            nb1  = Rx_NewByte;
            wr1  = Rx_WrBuff;
        end
    end

    initial begin
        int  n;
        bit  ab;
        Rst = 1'b1;
        Rx  = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        check("reset_rxd", RxD, 1'b1);
        check("reset_valid", Rx_ValidFrame, 1'b0);
        check("reset_data", Rx_Data, 8'h00);
        check("reset_size", Rx_FrameSize, 0);
        check("reset_status", {Rx_Overflow, Rx_FrameError, Rx_FCSerr, Rx_EoF, Rx_FlagDetect}, 5'b0);
        Rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            send_bit(1'b1);
            check("idle_outputs", {RxD, Rx_ValidFrame, Rx_FlagDetect, Rx_AbortDetect, Rx_StartZeroDetect,
                                   ZeroDetect, Rx_NewByte, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_Overflow},
                  11'h400);
        end

        push_byte(8'hA5);
        push_byte(8'h3C);
        run_frame(1'b0);
        idle(10);

        push_byte(8'hFF);
        run_frame(1'b0);
        idle(10);

        push_byte(8'h55);
        run_frame(1'b1);
        idle(10);

        push_byte(8'h5A);
        frame_bits.push_back(1'b1);
        frame_bits.push_back(1'b0);
        frame_bits.push_back(1'b1);
        frame_bits.push_back(1'b1);
        run_frame(1'b0);
        idle(10);

        repeat (MAX_BYTES + 1) push_byte(8'h00);
        run_frame(1'b0);
        idle(10);

        for (int f = 0; f < 25; f++) begin
            n  = $urandom_range(1, 60);
            ab = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < n; i++) frame_bits.push_back($urandom_range(0, 3) != 0);
            run_frame(ab);
            idle($urandom_range(0, 12));
        end

        idle(40);
        check("pending_flag_events", exp_flag.size(), 0);
        check("pending_abort_events", exp_abort.size(), 0);
        check("pending_bytes", exp_bytes.size(), 0);
        check("pending_eofs", exp_eof.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_deframer.md
Name: hdlc_rx_deframer

Overview:
Bit-serial HDLC receive front end.
- Samples the Rx line and detects flag, abort and idle patterns.
- Removes inserted zeros and assembles data bytes LSB-first.
- Frames data between opening and closing flags, and reports frame status strobes.
- Sits between the Rx pin and the Rx frame buffer; its outputs feed the buffer write port and the existing Rx assertion bench.

Parameters:
MAX_BYTES, 128, data bytes accepted per frame before Rx_Overflow asserts
SIZE_W, 8, width of Rx_FrameSize counter (must hold MAX_BYTES)

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  synchronous reset, active-high
Rx  input  1  serial receive line, idle high
RxD  output  1  Rx registered once
Rx_FlagDetect  output  1  one-cycle pulse, 01111110 seen
Rx_AbortDetect  output  1  one-cycle pulse, 0 followed by 7 ones seen
Rx_ValidFrame  output  1  high while inside a frame
Rx_StartZeroDetect  output  1  one-cycle pulse on first cycle of Rx_ValidFrame
ZeroDetect  output  1  one-cycle pulse when a stuffed zero is dropped
Rx_Data  output  8  last assembled byte
Rx_NewByte  output  1  one-cycle pulse, Rx_Data updated
Rx_WrBuff  output  1  Rx_NewByte gated by !Rx_Overflow
Rx_EoF  output  1  one-cycle end-of-frame pulse
Rx_AbortSignal  output  1  one-cycle pulse, frame ended by abort
Rx_FrameError  output  1  valid with Rx_EoF: closing flag not byte aligned
Rx_Overflow  output  1  sticky, more than MAX_BYTES bytes in frame
Rx_FrameSize  output  SIZE_W  bytes accepted, valid with Rx_EoF
Rx_FCSerr  output  1  valid with Rx_EoF, see optional feature

Behaviour:
- Reset values:
  - RxD=1 and shift window=0xFF.
  - All strobes, flags, counters and Rx_Data = 0.
  - Rx_ValidFrame = 0.
- Pipeline:
  - RxD <= Rx.
  - 8-bit window W shifts RxD in each cycle; newest bit is at W[7].
  - Rx_FlagDetect <= (W == 0x7E). It pulses exactly 2 cycles after the cycle where the flag's final 0 is on Rx.
  - Rx_AbortDetect <= (window holds 0 then seven 1s), same latency.
  - Abort does not retrigger while the line stays high.
- Data path: the bit leaving the window (W[0]) is the candidate data bit, so flag bits never reach the byte assembler.
- Ones counter (0..5) on the data bit stream:
  - If the count is 5 and the next bit is 0, drop the bit, pulse ZeroDetect and clear the count.
  - Any 0 clears the count.
- Byte assembly:
  - Bit counter 0..7 advances on each non-dropped data bit while Rx_ValidFrame=1; the LSB arrives first.
  - On the 8th bit, Rx_Data is loaded and Rx_NewByte pulses the next cycle.
- FSM states: IDLE, FRAME.
  - IDLE + Rx_FlagDetect -> FRAME. Rx_ValidFrame rises and Rx_StartZeroDetect pulses. Bit/byte counters and the ones counter clear, and Rx_Overflow clears.
  - FRAME + Rx_FlagDetect with byte count 0 and bit count 0: stay in FRAME (back-to-back or shared flags).
  - FRAME + Rx_FlagDetect otherwise -> IDLE. Rx_ValidFrame falls and Rx_EoF pulses the next cycle. Rx_FrameError = (bit count != 0). Rx_FrameSize = byte count.
  - FRAME + Rx_AbortDetect -> IDLE. Rx_ValidFrame falls, and Rx_AbortSignal and Rx_EoF pulse the next cycle. Rx_FrameError = 0.
  - IDLE + Rx_AbortDetect: no strobe.
  - If flag and abort would be detected in the same cycle, abort wins (this cannot occur with legal windows).
  - Partial bits present at frame end are discarded and no Rx_NewByte is generated.
- Overflow:
  - The byte counter saturates at MAX_BYTES.
  - On the (MAX_BYTES+1)th Rx_NewByte, Rx_Overflow rises the next cycle and stays high until the next opening flag.
  - Rx_WrBuff stays low for that byte and for later bytes.
- Reset mid-frame: return to IDLE immediately with no Rx_EoF; bytes received so far are lost.

Optional Feature:
RX_FCS_CHECK_EN:
- When defined:
  - CRC-16 (poly x^16+x^15+x^2+1, init 0x0000, LSB-first) runs over every assembled byte, including the two FCS bytes.
  - The CRC clears on the opening flag.
  - At Rx_EoF, Rx_FCSerr = (residue != 0), or 1 if Rx_FrameError=1; it is 0 on abort.
- When undefined: Rx_FCSerr is tied to 0 and no CRC logic exists. The port is present in both builds.

Test Plan:
- Reset, then Rx=1 for 50 cycles -> all strobes 0, RxD=1, Rx_ValidFrame=0.
- Flag, bytes 0xA5 0x3C, flag (no stuffing) -> Rx_FlagDetect 2 cycles after each flag's last bit. Rx_NewByte twice with Rx_Data 0xA5 then 0x3C. Rx_ValidFrame falls, then Rx_EoF the next cycle. Rx_FrameSize=2, Rx_FrameError=0.
- Flag, byte 0xFF sent as 11111 0 111, flag -> exactly one ZeroDetect, Rx_Data=0xFF, Rx_FrameSize=1.
- Flag, 0x55, then 0 followed by seven 1s -> Rx_AbortDetect, Rx_ValidFrame falls, Rx_AbortSignal and Rx_EoF the next cycle, Rx_FrameSize=1.
- Flag, 12 data bits, flag -> Rx_EoF with Rx_FrameError=1 and Rx_FrameSize=1.
- Flag, 129 bytes of 0x00, flag -> Rx_Overflow the cycle after the 129th Rx_NewByte. 128 Rx_WrBuff pulses. Rx_FrameSize=128. Rx_Overflow clears on the next opening flag.
